// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - byte-granular instruction prefetch queue with 6-byte fetch window
//
// Streams bytes from a 1-cycle-latency instruction memory into a circular
// byte queue and presents up to six bytes at the current fetch PC.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   instmem_addr      byte address read this cycle (the internal fetch PC)
//   instmem_rd        read issued this cycle
//   instmem_dataout   byte for the address issued in the previous cycle
//   redirect          flush queue and restart fetching at redirect_pc
//   redirect_pc       restart address
//   win_pc            byte address of window byte 0
//   win_bytes         window, byte i in bits [8i+7:8i], invalid bytes read 0
//   win_count         number of valid window bytes, 0..6
//   consume           drop consume_len bytes from the head this cycle
//   consume_len       1..6; ignored if 0 or larger than win_count
module inst_prefetch_queue #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instmem_addr,
    output logic        instmem_rd,
    input  logic [7:0]  instmem_dataout,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] win_pc,
    output logic [47:0] win_bytes,
    output logic [2:0]  win_count,
    input  logic        consume,
    input  logic [2:0]  consume_len
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    WIN_MAX  = (AW + 1)'(6);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   win_pc_q, win_pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          pending_q, pending_d;
    logic [7:0]    mem_q [DEPTH];

    logic [AW:0]   occupancy;
    logic          issue;
    logic          accept;
    logic [AW:0]   len_ext;
    logic [AW:0]   push_ext;

    // The in-flight byte reserves a slot so a full queue never overflows.
    assign occupancy = count_q + {{AW{1'b0}}, pending_q};
    assign issue     = !redirect && (occupancy < FULL_CNT);

    assign instmem_addr = fetch_pc_q;
    assign instmem_rd   = issue;
    assign win_pc       = win_pc_q;
    assign win_count    = (count_q >= WIN_MAX) ? 3'd6 : count_q[2:0];

    assign len_ext  = {{(AW - 2){1'b0}}, consume_len};
    assign push_ext = {{AW{1'b0}}, pending_q};
    assign accept   = consume && (consume_len != 3'd0) && (consume_len <= win_count);

    always_comb begin
        win_bytes = '0;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) < win_count) begin
                win_bytes[8*i +: 8] = mem_q[head_q + AW'(i)];
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        win_pc_d   = win_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pending_d  = issue;
        count_d    = count_q + push_ext - (accept ? len_ext : '0);

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd1;
        end
        if (pending_q) begin
            tail_d = tail_q + AW'(1);
        end
        if (accept) begin
            head_d   = head_q + consume_len;
            win_pc_d = win_pc_q + {29'd0, consume_len};
        end

        // Redirect wins: the byte returning next cycle belongs to the old
        // stream, so clearing pending drops it on arrival.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            win_pc_d   = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            win_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            win_pc_q   <= win_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
        end
    end

    // Storage needs no reset: count masks stale entries, and reset clears
    // pending asynchronously so an in-flight byte is never written.
    always_ff @(posedge clk) begin
        if (pending_q && !redirect) begin
            mem_q[tail_q] <= instmem_dataout;
        end
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Byte-granular instruction prefetch buffer between the 8-bit instruction memory and the fetch stage. It streams bytes from `instmem` at one byte per cycle into a circular queue, and presents the 6-byte window at the current fetch PC, enough for the widest 48-bit instruction. The fetch stage consumes 1..6 bytes per cycle, and any taken jump (`t_do_jmp`/`d_do_jmp`/`m_do_jmp`) is delivered as a redirect that flushes the queue. This decouples variable-length instruction assembly from the instruction memory read latency.

## Interface
- `DEPTH`, 16: queue capacity in bytes; power of two, ≥ 8.
- `RESET_PC`, 32'h0: first fetch address after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instmem_addr` out 32: byte address being read this cycle; always equals internal `fetch_pc`.
- `instmem_rd` out 1: read issued this cycle.
- `instmem_dataout` in 8: byte at the address issued in the previous cycle (registered memory, 1-cycle latency).
- `redirect` in 1: flush and restart fetching at `redirect_pc`.
- `redirect_pc` in 32: new fetch address, sampled when `redirect`=1.
- `win_pc` out 32: byte address of window byte 0.
- `win_bytes` out 48: window; byte i in bits [8i+7:8i]; bytes at index ≥ `win_count` read as 0.
- `win_count` out 3: valid window bytes, 0..6 (min(count,6)).
- `consume` in 1: drop `consume_len` bytes from the head at end of cycle.
- `consume_len` in 3: 1..6.

## Operation
State: `fetch_pc`, `head`, `tail` (log2 DEPTH bits, wrap mod DEPTH), `count` (0..DEPTH), `pending` (1 bit), storage array, `win_pc`.
- Issue: `instmem_rd` = !`redirect` && (`count` + `pending` < DEPTH), using registered values only. On issue, `fetch_pc` += 1 (mod 2^32) and `pending` <= 1. With no issue, `pending` <= 0.
- Return: if `pending`=1, `instmem_dataout` is written at `tail`, then `tail`+1 and `count`+1.
- Consume: accepted only if `consume`=1 and 1 ≤ `consume_len` ≤ `win_count`. On accept, `head` += `consume_len`, `win_pc` += `consume_len`, and `count` -= `consume_len`. An invalid consume is ignored with no state change.
- Push and consume in the same cycle are both applied: `count` <= `count` + push − len.
- Redirect has priority over everything. At the end of the cycle, `head`=`tail`=0, `count`=0, `pending`=0 (the in-flight byte returning next cycle is discarded), `fetch_pc`=`win_pc`=`redirect_pc`. Consume and push in that cycle are dropped.
- Window is combinational from `head`, `count` and the storage array, with index wrap mod DEPTH.
- Address arithmetic is 32-bit modulo. The window may span 32'hFFFFFFFF→0 with no special case.

## Timing
- Reset values: `instmem_addr`=`RESET_PC`, `win_pc`=`RESET_PC`, `win_count`=0, `win_bytes`=0, `count`=0, `pending`=0. `instmem_rd` is 1 during reset deassertion (count+pending=0 < DEPTH).
- Read latency: issue in cycle c, data valid in c+1, byte visible in the window in c+2.
- From reset release (cycle 0 = first issue): `win_count` is 0,0,1,2,3,4,5,6 in cycles 0..7.
- Redirect in cycle r: `win_count`=0 in r+1 and r+2. The first `redirect_pc` issue is in r+1, and `win_count`=1 with `win_pc`=`redirect_pc` in r+3.
- Full: with `count`+`pending`=DEPTH, `instmem_rd`=0 and `instmem_addr` holds. Issue resumes the cycle after a consume frees space.
- Steady state: 1 byte/cycle throughput. A sustained consume of N bytes/cycle > 1 drains the window.
- Reset asserted mid-operation: all state returns to reset values immediately, and an in-flight byte is never written.

## Test plan
- Reset then no consume, memory byte[a]=a[7:0]: `win_count` ramps 0,0,1..6 over cycles 0..7; `win_bytes`=48'h050403020100; `instmem_rd` drops after `count` reaches 16.
- After full, consume 3 per cycle for 2 cycles: `win_pc` goes 0→3→6 and `win_bytes`=48'h0B0A09080706; issue restarts one cycle after the first consume.
- Redirect to 32'h100 while `pending`=1: the stale byte is discarded; `win_count`=0 for two cycles, then `win_pc`=32'h100 and byte 0=8'h00 (mem[0x100]) in r+3.
- Redirect and consume=1 in the same cycle: consume is ignored and `win_pc`=`redirect_pc`.
- consume_len=5 with `win_count`=3, and consume_len=0: no state change.
- Redirect to 32'hFFFFFFFE: the window contains bytes FE,FF,00,01…; `win_pc` after consume 4 is 32'h00000002. Assert `reset` mid-fill: outputs match reset values within the same cycle.
